mem_arbiter: RTL and testbench

//  Shares one synchronous memory port between the IF stage (instruction fetch)
//  and the MEM stage (data load/store) of the 5-stage MIPS32 pipeline.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between instruction fetch
// (i_*) and data load/store (d_*). Data wins ties because MEM holds the older
// instruction. Acks are combinational off mem_ready; mem_* are registered.
// Optional feature macro: ARB_TIMEOUT_EN (busy-cycle watchdog that forces an
// error completion after TIMEOUT_CYCLES cycles without mem_ready).
module mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_sel,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_sel,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem
);

    // Byte enables are 4 bits wide, so only a 32-bit data path makes sense;
    // the busy counter is 8 bits, bounding the timeout.
    if (DW != 32) begin : g_bad_dw
        $error("mem_arbiter: DW must be 32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be 1..256");
    end

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t state, state_nxt;
    logic   load_i, load_d, clear_bus;
    logic   busy, done, timeout_fire;

    assign busy = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] busy_cnt;

    // Watchdog: restart on every grant, count busy cycles without mem_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    busy_cnt <= '0;
        else if (load_i || load_d)   busy_cnt <= '0;
        else if (busy && !mem_ready) busy_cnt <= busy_cnt + 8'd1;
    end

    assign timeout_fire = busy && !mem_ready && (busy_cnt == TO_LAST);
`else
    assign timeout_fire = 1'b0;
`endif

    // A busy cycle ends on mem_ready or a forced timeout; IDLE ignores mem_ready.
    assign done = busy && (mem_ready || timeout_fire);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: on completion only the other requester may be granted,
    // since the finishing one still shows a stale req this cycle.
    always_comb begin
        state_nxt = state;
        load_i    = 1'b0;
        load_d    = 1'b0;
        clear_bus = 1'b0;
        case (state)
            IDLE: begin
                if (d_req) begin
                    state_nxt = D_BUSY;
                    load_d    = 1'b1;
                end else if (i_req) begin
                    state_nxt = I_BUSY;
                    load_i    = 1'b1;
                end
            end
            I_BUSY: begin
                if (done) begin
                    if (d_req) begin
                        state_nxt = D_BUSY;
                        load_d    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clear_bus = 1'b1;
                    end
                end
            end
            D_BUSY: begin
                if (done) begin
                    if (i_req) begin
                        state_nxt = I_BUSY;
                        load_i    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clear_bus = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                clear_bus = 1'b1;
            end
        endcase
    end

    // Memory-side request register: latched at grant, held until completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= 4'b0000;
        end else if (load_d) begin
            mem_ce    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel   <= d_sel;
        end else if (load_i) begin
            mem_ce    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_sel   <= 4'b1111;
        end else if (clear_bus) begin
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= 4'b0000;
        end
    end

    // Requester responses; read data is zeroed unless a real completion.
    always_comb begin
        i_ack     = (state == I_BUSY) && done;
        d_ack     = (state == D_BUSY) && done;
        i_err     = i_ack && timeout_fire;
        d_err     = d_ack && timeout_fire;
        i_rdata   = (i_ack && !timeout_fire) ? mem_rdata : '0;
        d_rdata   = (d_ack && !timeout_fire) ? mem_rdata : '0;
        stall_if  = i_req && !i_ack;
        stall_mem = d_req && !d_ack;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected acks;
// a negedge monitor pops and checks every ack the DUT presents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_sel;
    logic        i_ack, i_err, d_ack, d_err, mem_ce, mem_we, stall_if, stall_mem;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic expect_ack(input logic is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        chk("dual_ack", 32'(i_ack & d_ack), 32'd0);
        if (!i_ack) chk("i_rdata_idle", i_rdata, 32'd0);
        if (!d_ack) chk("d_rdata_idle", d_rdata, 32'd0);
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none at %0t",
                         i_ack, d_ack, $time);
            end else begin
                e = sb.pop_front();
                chk("ack_src",   32'(d_ack), 32'(e.is_d));
                chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
                chk("ack_err",   32'(d_ack ? d_err : i_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_sel = 0; mem_rdata = 0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_ce", 32'(mem_ce), 0);   chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);    chk("rst_wdata", mem_wdata, 0);
        chk("rst_sel", 32'(mem_sel), 0); chk("rst_stall_if", 32'(stall_if), 0);
        chk("rst_stall_mem", 32'(stall_mem), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // Idle bus with mem_ready high: nothing happens.
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            smp(); chk("idle_ce", 32'(mem_ce), 0);
            nxt();
        end

        // Single fetch, zero wait states.
        i_req = 1; i_addr = 32'h4; mem_ready = 1; mem_rdata = 32'h3401_0001;
        expect_ack(1'b0, 32'h3401_0001, 1'b0);
        smp(); chk("f_c0_ce", 32'(mem_ce), 0); chk("f_c0_stall", 32'(stall_if), 1);
        nxt(); smp();
        chk("f_c1_ce", 32'(mem_ce), 1);     chk("f_c1_addr", mem_addr, 32'h4);
        chk("f_c1_we", 32'(mem_we), 0);     chk("f_c1_sel", 32'(mem_sel), 32'hF);
        chk("f_c1_ack", 32'(i_ack), 1);     chk("f_c1_stall", 32'(stall_if), 0);
        nxt(); i_req = 0;
        smp(); chk("f_c2_ce", 32'(mem_ce), 0);

        // Back-to-back fetches from the same requester: one IDLE bubble.
        nxt(); i_req = 1; i_addr = 32'h8; mem_rdata = 32'hA1A1_A1A1;
        expect_ack(1'b0, 32'hA1A1_A1A1, 1'b0);
        nxt(); smp(); chk("bb_c1_ack", 32'(i_ack), 1);
        nxt(); i_addr = 32'hC; mem_rdata = 32'hA2A2_A2A2;
        expect_ack(1'b0, 32'hA2A2_A2A2, 1'b0);
        smp(); chk("bb_gap_ce", 32'(mem_ce), 0); chk("bb_gap_stall", 32'(stall_if), 1);
        nxt(); smp(); chk("bb_c3_addr", mem_addr, 32'hC); chk("bb_c3_ack", 32'(i_ack), 1);
        nxt(); i_req = 0;

        // Contention: data first, then fetch with no bubble.
        nxt();
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_sel = 4'hF;
        mem_ready = 1; mem_rdata = 32'h1111_1111;
        expect_ack(1'b1, 32'h1111_1111, 1'b0);
        smp(); chk("c_c0_ce", 32'(mem_ce), 0);
        chk("c_c0_stall_if", 32'(stall_if), 1); chk("c_c0_stall_mem", 32'(stall_mem), 1);
        nxt(); smp();
        chk("c_c1_we", 32'(mem_we), 1);      chk("c_c1_addr", mem_addr, 32'h10);
        chk("c_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("c_c1_dack", 32'(d_ack), 1);     chk("c_c1_stall_if", 32'(stall_if), 1);
        chk("c_c1_stall_mem", 32'(stall_mem), 0);
        nxt(); d_req = 0; d_we = 0; mem_rdata = 32'h2222_2222;
        expect_ack(1'b0, 32'h2222_2222, 1'b0);
        smp();
        chk("c_c2_ce", 32'(mem_ce), 1);      chk("c_c2_addr", mem_addr, 32'h20);
        chk("c_c2_we", 32'(mem_we), 0);      chk("c_c2_iack", 32'(i_ack), 1);
        nxt(); i_req = 0;
        smp(); chk("c_c3_ce", 32'(mem_ce), 0);

        // Load with 3 wait states.
        nxt(); d_req = 1; d_we = 0; d_addr = 32'h40; d_sel = 4'b0011; mem_ready = 0;
        mem_rdata = 32'h5555_5555;
        for (int k = 1; k <= 3; k++) begin
            nxt(); smp();
            chk("w_addr", mem_addr, 32'h40); chk("w_sel", 32'(mem_sel), 32'h3);
            chk("w_we", 32'(mem_we), 0);     chk("w_stall", 32'(stall_mem), 1);
            chk("w_ack", 32'(d_ack), 0);
        end
        nxt(); mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        expect_ack(1'b1, 32'hCAFE_F00D, 1'b0);
        smp(); chk("w_ack_cyc", 32'(d_ack), 1); chk("w_stall_end", 32'(stall_mem), 0);
        nxt(); d_req = 0; mem_ready = 0;
        smp(); chk("w_end_ce", 32'(mem_ce), 0);

        // Reset during D_BUSY: bus clears immediately, no ack.
        nxt(); d_req = 1; d_we = 0; d_addr = 32'h50; d_sel = 4'hF;
        nxt(); smp(); chk("r_c1_ce", 32'(mem_ce), 1);
        nxt(); #2 rst = 1'b0;
        #1;
        chk("r_ce", 32'(mem_ce), 0);  chk("r_addr", mem_addr, 0);
        chk("r_sel", 32'(mem_sel), 0); chk("r_dack", 32'(d_ack), 0);
        d_req = 0;
        nxt(); rst = 1'b1; mem_ready = 1;
        smp(); chk("r_idle_ce", 32'(mem_ce), 0);
        // Arbiter must be IDLE: a fresh fetch sees normal one-cycle latency.
        nxt(); i_req = 1; i_addr = 32'h60; mem_rdata = 32'h0000_0005;
        expect_ack(1'b0, 32'h0000_0005, 1'b0);
        smp(); chk("r_f0_ce", 32'(mem_ce), 0);
        nxt(); smp(); chk("r_f1_ack", 32'(i_ack), 1);
        nxt(); i_req = 0; mem_ready = 0;

`ifdef ARB_TIMEOUT_EN
        // Timeout: 8th busy cycle is forced to an error completion.
        nxt(); d_req = 1; d_we = 0; d_addr = 32'h70; mem_rdata = 32'h9999_9999;
        expect_ack(1'b1, 32'h0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            nxt(); smp();
            chk("to_ce", 32'(mem_ce), 1);
            chk("to_ack", 32'(d_ack), (k == 8) ? 32'd1 : 32'd0);
            chk("to_err", 32'(d_err), (k == 8) ? 32'd1 : 32'd0);
        end
        nxt(); d_req = 0;
        smp(); chk("to_end_ce", 32'(mem_ce), 0);
`else
        // No timeout: transaction waits indefinitely.
        nxt(); d_req = 1; d_we = 0; d_addr = 32'h70;
        for (int k = 1; k <= 100; k++) begin
            nxt(); smp(); chk("nto_ack", 32'(d_ack), 0);
        end
        chk("nto_ce", 32'(mem_ce), 1);
        #1 rst = 1'b0; d_req = 0;
        nxt(); rst = 1'b1;
`endif

        nxt(); smp();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
